// File: rtl/kernel_pingpong_buffer_pkg.sv
// Shared complex word type and sizing helpers
// for the double-buffered kernel store.
package kernel_pingpong_buffer_pkg;

  typedef struct packed {
    logic [31:0] r;
    logic [31:0] i;
  } complex_t;

  localparam int CPLX_W = $bits(complex_t);

  function automatic int kb_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit kb_is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  function automatic int kb_beats(
    input int lanes,
    input int words
  );
    return lanes / words;
  endfunction

  function automatic bit kb_beats_ok(
    input int lanes,
    input int words
  );
    return (words > 0)
      && (lanes % words == 0)
      && kb_is_pow2(lanes / words);
  endfunction

endpackage

// File: rtl/kernel_pingpong_buffer_if.sv
// Write-beat, row-read and bank-status bundle
// between the line fetcher, the store and the MAC array.
interface kernel_pingpong_buffer_if #(
  parameter int LANES      = 16,
  parameter int LINE_WORDS = 8,
  parameter int DEPTH      = 512,
  parameter int NUM_BANKS  = 2
);
  import kernel_pingpong_buffer_pkg::*;

  localparam int ADDR_W = kb_clog2(DEPTH);

  logic [ADDR_W:0]           cfg_len;
  logic                      wr_valid;
  logic                      wr_ready;
  complex_t [0:LINE_WORDS-1] wr_data;
  logic                      rd_en;
  logic [ADDR_W-1:0]         rd_addr;
  complex_t [0:LANES-1]      rd_data;
  logic                      rd_valid;
  logic                      rd_bank_ready;
  logic                      rd_release;
  logic [NUM_BANKS-1:0]      bank_full;

  modport master (
    output cfg_len,
    output wr_valid,
    output wr_data,
    output rd_en,
    output rd_addr,
    output rd_release,
    input  wr_ready,
    input  rd_data,
    input  rd_valid,
    input  rd_bank_ready,
    input  bank_full
  );

  modport slave (
    input  cfg_len,
    input  wr_valid,
    input  wr_data,
    input  rd_en,
    input  rd_addr,
    input  rd_release,
    output wr_ready,
    output rd_data,
    output rd_valid,
    output rd_bank_ready,
    output bank_full
  );

endinterface

// File: rtl/dual_port_ram.sv
// Generic simple dual-port RAM, one write port
// and one registered read port, no reset.
module dual_port_ram #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/kernel_pingpong_buffer.sv
// Multi-bank ping-pong kernel store: packs line beats
// into kernel rows and hands full banks to the reader.
module kernel_pingpong_buffer
  import kernel_pingpong_buffer_pkg::*;
#(
  parameter int LANES      = 16,
  parameter int LINE_WORDS = 8,
  parameter int DEPTH      = 512,
  parameter int NUM_BANKS  = 2
) (
  input logic clk,
  input logic reset,
  kernel_pingpong_buffer_if.slave bus
);

  localparam int ADDR_W = kb_clog2(DEPTH);
  localparam int LEN_W  = ADDR_W + 1;
  localparam int BEATS  = kb_beats(LANES, LINE_WORDS);
  localparam int BEAT_W = kb_clog2(BEATS);
  localparam int BANK_W = kb_clog2(NUM_BANKS);
  localparam int LINE_W = LINE_WORDS * CPLX_W;

  if (!kb_beats_ok(LANES, LINE_WORDS) || NUM_BANKS < 2)
  begin : g_bad_cfg
    $error("kernel_pingpong_buffer: bad geometry");
  end

  function automatic logic [BANK_W-1:0] bank_inc(
    input logic [BANK_W-1:0] b
  );
    return (b == BANK_W'(NUM_BANKS - 1)) ? '0 : b + 1'b1;
  endfunction

  logic [BANK_W-1:0]    wr_bank_q, wr_bank_d;
  logic [BANK_W-1:0]    rd_bank_q, rd_bank_d;
  logic [BANK_W-1:0]    rd_sel_q, rd_sel_d;
  logic [NUM_BANKS-1:0] full_q, full_d;
  logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0]    row_cnt_q, row_cnt_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic                 rd_valid_q, rd_valid_d;

  logic             wr_fire;
  logic             rd_fire;
  logic             rel_fire;
  logic             first_beat;
  logic             row_end;
  logic             fill_end;
  logic [LEN_W-1:0] cfg_eff;
  logic [LEN_W-1:0] cur_len;

  always_comb begin
    cfg_eff = bus.cfg_len;
    if (bus.cfg_len == '0 ||
        bus.cfg_len > LEN_W'(DEPTH)) begin
      cfg_eff = LEN_W'(DEPTH);
    end
    wr_fire  = bus.wr_valid && !full_q[wr_bank_q];
    rd_fire  = bus.rd_en && full_q[rd_bank_q];
    rel_fire = bus.rd_release && full_q[rd_bank_q];
    first_beat = (row_cnt_q == '0) && (beat_cnt_q == '0);
    // the fill length is only live from the first beat on
    cur_len  = first_beat ? cfg_eff : len_q;
    row_end  = beat_cnt_q == BEAT_W'(BEATS - 1);
    fill_end = row_end &&
      (LEN_W'(row_cnt_q) == cur_len - LEN_W'(1));

    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    full_d     = full_q;
    beat_cnt_d = beat_cnt_q;
    row_cnt_d  = row_cnt_q;
    len_d      = len_q;
    rd_valid_d = rd_fire;
    rd_sel_d   = rd_fire ? rd_bank_q : rd_sel_q;

    if (wr_fire) begin
      if (first_beat) begin
        len_d = cfg_eff;
      end
      beat_cnt_d = row_end ? '0 : beat_cnt_q + 1'b1;
      if (row_end) begin
        row_cnt_d = row_cnt_q + 1'b1;
      end
      if (fill_end) begin
        full_d[wr_bank_q] = 1'b1;
        row_cnt_d = '0;
        wr_bank_d = bank_inc(wr_bank_q);
      end
    end

    if (rel_fire) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d = bank_inc(rd_bank_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank_q  <= '0;
      rd_bank_q  <= '0;
      rd_sel_q   <= '0;
      full_q     <= '0;
      beat_cnt_q <= '0;
      row_cnt_q  <= '0;
      len_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      rd_sel_q   <= rd_sel_d;
      full_q     <= full_d;
      beat_cnt_q <= beat_cnt_d;
      row_cnt_q  <= row_cnt_d;
      len_q      <= len_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  logic [LINE_W-1:0] wr_line;
  logic [LINE_W-1:0] ram_rd [NUM_BANKS][BEATS];

  always_comb begin
    wr_line = '0;
    for (int w = 0; w < LINE_WORDS; w++) begin
      wr_line[w*CPLX_W +: CPLX_W] = bus.wr_data[w];
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    for (genvar s = 0; s < BEATS; s++) begin : g_sub
      logic we;

      assign we = wr_fire
        && (wr_bank_q == BANK_W'(b))
        && (beat_cnt_q == BEAT_W'(s));

      dual_port_ram #(
        .WIDTH (LINE_W),
        .DEPTH (DEPTH),
        .AW    (ADDR_W)
      ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (row_cnt_q),
        .wdata (wr_line),
        .re    (rd_fire),
        .raddr (bus.rd_addr),
        .rdata (ram_rd[b][s])
      );
    end
  end

  // bank select follows the read, so a same-cycle release
  // cannot steer the returning row to the next bank
  always_comb begin
    bus.rd_data = '0;
    if (rd_valid_q) begin
      for (int l = 0; l < LANES; l++) begin
        bus.rd_data[l] =
          ram_rd[rd_sel_q][l / LINE_WORDS]
                [(l % LINE_WORDS)*CPLX_W +: CPLX_W];
      end
    end
  end

  assign bus.wr_ready      = !full_q[wr_bank_q];
  assign bus.rd_bank_ready = full_q[rd_bank_q];
  assign bus.rd_valid      = rd_valid_q;
  assign bus.bank_full     = full_q;

endmodule

// File: tb/tb_kernel_pingpong_buffer.sv
// Directed vector bench for kernel_pingpong_buffer
// (default geometry: 16 lanes, 8-word beats, 512 rows, 2 banks).
module tb_kernel_pingpong_buffer;
  import kernel_pingpong_buffer_pkg::*;

  localparam int LN = 16;
  localparam int LW = 8;

  typedef struct {
    string      name;
    bit         rst;
    logic [9:0] len;
    bit         wv;
    int         k;
    bit         re;
    logic [8:0] ra;
    bit         rel;
    bit         ewr;
    bit         erbr;
    logic [1:0] efull;
    bit         erv;
    bit         dchk;
    int         lo;
    int         hi;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  bit   early;
  vec_t tbl[$];

  kernel_pingpong_buffer_if bus ();

  kernel_pingpong_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic complex_t cx(input int k);
    complex_t c;
    c.r = 32'(k);
    c.i = 32'(k + 100);
    return c;
  endfunction

  function automatic vec_t mk(
    input string n, input bit rst, input int len,
    input bit wv, input int k, input bit re,
    input int ra, input bit rel, input bit ewr,
    input bit erbr, input int efull, input bit erv,
    input bit dchk, input int lo, input int hi
  );
    vec_t v;
    v.name = n; v.rst = rst; v.len = 10'(len);
    v.wv = wv; v.k = k; v.re = re; v.ra = 9'(ra);
    v.rel = rel; v.ewr = ewr; v.erbr = erbr;
    v.efull = 2'(efull); v.erv = erv; v.dchk = dchk;
    v.lo = lo; v.hi = hi;
    return v;
  endfunction

  task automatic chk(
    input string nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst;
    bus.cfg_len = v.len;
    bus.wr_valid = v.wv;
    for (int w = 0; w < LW; w++) bus.wr_data[w] = cx(v.k);
    bus.rd_en = v.re;
    bus.rd_addr = v.ra;
    bus.rd_release = v.rel;
  endtask

  task automatic check(input vec_t v);
    chk({v.name, ".wr_ready"}, 64'(bus.wr_ready), 64'(v.ewr));
    chk({v.name, ".rd_bank_ready"},
        64'(bus.rd_bank_ready), 64'(v.erbr));
    chk({v.name, ".bank_full"},
        64'(bus.bank_full), 64'(v.efull));
    chk({v.name, ".rd_valid"}, 64'(bus.rd_valid), 64'(v.erv));
    if (v.dchk) begin
      for (int l = 0; l < LN; l++) begin
        complex_t e;
        e = '0;
        if (v.erv) e = cx(l < LW ? v.lo : v.hi);
        chk($sformatf("%s.lane%0d", v.name, l),
            bus.rd_data[l], e);
      end
    end
  endtask

  task automatic apply(input vec_t v);
    drive(v);
    @(posedge clk);
    #1;
    check(v);
  endtask

  task automatic long_fill(input string n, input int len);
    early = 1'b0;
    for (int i = 0; i < 1023; i++) begin
      drive(mk(n, 0, len, 1, i, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      if (bus.bank_full != 2'b00 && len == 0) early = 1'b1;
      if (bus.bank_full != 2'b00 && len != 0) early = 1'b1;
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    early = 1'b0;

    // reset and idle
    tbl.push_back(mk("t1_rst", 1, 0, 0, 0, 0, 0, 0,
                     1, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk("t1_idle", 0, 0, 0, 0, 0, 0, 0,
                       1, 0, 0, 0, i == 4, 0, 0));

    // 4-row fill; cfg_len changes after the first beat
    tbl.push_back(mk("t2_b0", 0, 4, 1, 0, 0, 0, 0,
                     1, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k < 7; k++)
      tbl.push_back(mk("t2_b", 0, 1, 1, k, 0, 0, 0,
                       1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("t2_b7", 0, 1, 1, 7, 0, 0, 0,
                     1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk("t2_rd2", 0, 0, 0, 0, 1, 2, 0,
                     1, 1, 1, 1, 1, 4, 5));
    tbl.push_back(mk("t2_rd0", 0, 0, 0, 0, 1, 0, 0,
                     1, 1, 1, 1, 1, 0, 1));
    tbl.push_back(mk("t2_rd3", 0, 0, 0, 0, 1, 3, 0,
                     1, 1, 1, 1, 1, 6, 7));
    tbl.push_back(mk("t2_idle", 0, 0, 0, 0, 0, 0, 0,
                     1, 1, 1, 0, 1, 0, 0));

    // both banks full, write back-pressure, release
    tbl.push_back(mk("t3_rst", 1, 0, 0, 0, 0, 0, 0,
                     1, 0, 0, 0, 0, 0, 0));
    for (int k = 10; k < 13; k++)
      tbl.push_back(mk("t3_a", 0, 2, 1, k, 0, 0, 0,
                       1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("t3_a3", 0, 2, 1, 13, 0, 0, 0,
                     1, 1, 1, 0, 0, 0, 0));
    for (int k = 20; k < 23; k++)
      tbl.push_back(mk("t3_b", 0, 2, 1, k, 0, 0, 0,
                       1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk("t3_b3", 0, 2, 1, 23, 0, 0, 0,
                     0, 1, 3, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk("t3_hold", 0, 2, 1, 30, 0, 0, 0,
                       0, 1, 3, 0, 0, 0, 0));
    tbl.push_back(mk("t3_h9", 0, 2, 1, 30, 1, 0, 0,
                     0, 1, 3, 1, 1, 10, 11));
    tbl.push_back(mk("t3_rel", 0, 2, 1, 30, 1, 1, 1,
                     1, 1, 2, 1, 1, 12, 13));
    tbl.push_back(mk("t3_h11", 0, 2, 1, 30, 1, 0, 0,
                     1, 1, 2, 1, 1, 20, 21));

    // fill end and release in one cycle; release of write bank
    tbl.push_back(mk("t4_rst", 1, 0, 0, 0, 0, 0, 0,
                     1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("t4_a0", 0, 1, 1, 40, 0, 0, 0,
                     1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("t4_a1", 0, 1, 1, 41, 0, 0, 0,
                     1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk("t4_b0", 0, 1, 1, 50, 0, 0, 0,
                     1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk("t4_sim", 0, 1, 1, 51, 0, 0, 1,
                     1, 1, 2, 0, 0, 0, 0));
    tbl.push_back(mk("t4_rd", 0, 1, 0, 0, 1, 0, 0,
                     1, 1, 2, 1, 1, 50, 51));
    tbl.push_back(mk("t4_c0", 0, 1, 1, 60, 0, 0, 0,
                     1, 1, 2, 0, 0, 0, 0));
    tbl.push_back(mk("t4_c1", 0, 1, 1, 61, 0, 0, 0,
                     0, 1, 3, 0, 0, 0, 0));
    tbl.push_back(mk("t4_relw", 0, 1, 1, 70, 0, 0, 1,
                     1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk("t4_d0", 0, 1, 1, 70, 0, 0, 0,
                     1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk("t4_d1", 0, 1, 1, 71, 0, 0, 0,
                     0, 1, 3, 0, 0, 0, 0));
    tbl.push_back(mk("t4_rdc", 0, 1, 0, 0, 1, 0, 0,
                     0, 1, 3, 1, 1, 60, 61));
    tbl.push_back(mk("t4_rel2", 0, 1, 0, 0, 0, 0, 1,
                     1, 1, 2, 0, 0, 0, 0));
    tbl.push_back(mk("t4_rdd", 0, 1, 0, 0, 1, 0, 0,
                     1, 1, 2, 1, 1, 70, 71));

    for (int n = 0; n < tbl.size(); n++) apply(tbl[n]);

    // reset mid-fill drops the partial fill
    apply(mk("t5_rst", 1, 0, 0, 0, 0, 0, 0,
             1, 0, 0, 0, 0, 0, 0));
    for (int k = 80; k < 83; k++)
      apply(mk("t5_p", 0, 4, 1, k, 0, 0, 0,
               1, 0, 0, 0, 0, 0, 0));
    apply(mk("t5_rst2", 1, 0, 0, 0, 0, 0, 0,
             1, 0, 0, 0, 0, 0, 0));
    apply(mk("t5_b0", 0, 1, 1, 90, 0, 0, 0,
             1, 0, 0, 0, 0, 0, 0));
    apply(mk("t5_b1", 0, 1, 1, 91, 0, 0, 0,
             1, 1, 1, 0, 0, 0, 0));
    apply(mk("t5_rd", 0, 1, 0, 0, 1, 0, 0,
             1, 1, 1, 1, 1, 90, 91));

    // cfg_len 0 means a full-depth fill
    apply(mk("t6_rst", 1, 0, 0, 0, 0, 0, 0,
             1, 0, 0, 0, 0, 0, 0));
    long_fill("t6_fill", 0);
    chk("t6_no_early_full", 64'(early), 64'(0));
    apply(mk("t6_early", 0, 0, 0, 0, 1, 0, 1,
             1, 0, 0, 0, 0, 0, 0));
    apply(mk("t6_idle", 0, 0, 0, 0, 0, 0, 0,
             1, 0, 0, 0, 1, 0, 0));
    apply(mk("t6_last", 0, 0, 1, 1023, 0, 0, 0,
             1, 1, 1, 0, 0, 0, 0));
    apply(mk("t6_rd", 0, 0, 0, 0, 1, 511, 0,
             1, 1, 1, 1, 1, 1022, 1023));

    // cfg_len above DEPTH also means a full-depth fill
    apply(mk("t6_rel", 0, 0, 0, 0, 0, 0, 1,
             1, 0, 0, 0, 0, 0, 0));
    long_fill("t6b_fill", 600);
    chk("t6b_no_early_full", 64'(early), 64'(0));
    apply(mk("t6b_last", 0, 600, 1, 1023, 0, 0, 0,
             1, 1, 2, 0, 0, 0, 0));
    apply(mk("t6b_rd", 0, 0, 0, 0, 1, 511, 0,
             1, 1, 2, 1, 1, 1022, 1023));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
